// File: rtl/unidirectional_bus.sv
// Registered one-direction bus driver: samples (a, c) each clock and drives b from registers only.
// Optional UNIDIRECTIONAL_BUS_KEEPER_EN: b holds the last driven word instead of floating when idle.
module unidirectional_bus #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             c,
  output logic [WIDTH-1:0] b,
  output logic             b_valid,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [WIDTH-1:0] data_q;
  logic             en_q;
  logic [CNT_W-1:0] cnt_q;

  // Capture word and enable; count every cycle the bus was driven (wraps naturally).
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      en_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= a;
      en_q   <= c;
      if (en_q) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef UNIDIRECTIONAL_BUS_KEEPER_EN
  logic [WIDTH-1:0] hold_q;

  // Remember the last word actually driven so the idle bus repeats it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (en_q) begin
      hold_q <= data_q;
    end
  end

  assign b = en_q ? data_q : hold_q;
`else
  assign b = en_q ? data_q : {WIDTH{1'bz}};
`endif

  assign b_valid  = en_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_unidirectional_bus.sv
// Scoreboard bench for unidirectional_bus: a reference model queues expected outputs per edge,
// a negedge monitor pops and compares. Honors UNIDIRECTIONAL_BUS_KEEPER_EN.
module tb_unidirectional_bus;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  typedef struct {
    logic [WIDTH-1:0] b;
    logic             valid;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic             c;
  wire  [WIDTH-1:0] b;
  logic             b_valid;
  logic [CNT_W-1:0] xfer_cnt;

  unidirectional_bus #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .a(a), .c(c),
    .b(b), .b_valid(b_valid), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Reference model state, expressed as sample history since the last reset.
  int unsigned      enabled_samples = 0;   // samples with c=1, excluding the newest
  logic [WIDTH-1:0] last_driven     = '0;  // most recent word sampled with c=1

  task automatic model_edge(input logic r, input logic [WIDTH-1:0] av, input logic cv);
    exp_t e;
    e.tag = phase;
    if (r) begin
      enabled_samples = 0;
      last_driven     = '0;
`ifdef UNIDIRECTIONAL_BUS_KEEPER_EN
      e.b = '0;
`else
      e.b = 'z;
`endif
      e.valid = 1'b0;
      e.cnt   = '0;
    end else begin
      e.cnt   = CNT_W'(enabled_samples % (1 << CNT_W));
      e.valid = cv;
`ifdef UNIDIRECTIONAL_BUS_KEEPER_EN
      e.b = cv ? av : last_driven;
`else
      e.b = cv ? av : 'z;
`endif
      if (cv) begin
        enabled_samples++;
        last_driven = av;
      end
    end
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic [WIDTH-1:0] av, input logic cv);
    rst = r; a = av; c = cv;
    @(posedge clk);
    model_edge(r, av, cv);
    #1;
  endtask

  task automatic check(input string name, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] req, input string tag);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s [%s] t=%0t actual=%b required=%b", name, tag, $time, act, req);
    end
  endtask

  // Monitor: one expected entry per clock, compared away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("b", CNT_W'(b), CNT_W'(e.b), e.tag);
      check("b_valid", CNT_W'(b_valid), CNT_W'(e.valid), e.tag);
      check("xfer_cnt", xfer_cnt, e.cnt, e.tag);
    end
  end

  initial begin
    rst = 1'b1; a = 4'hA; c = 1'b1;
    #1;
    phase = "reset";
    step(1'b1, 4'hA, 1'b1);
    step(1'b1, 4'hA, 1'b1);

    phase = "sweep";
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 10; k++) step(1'b0, WIDTH'(i), 1'b0);
      for (int k = 0; k < 10; k++) step(1'b0, WIDTH'(i), 1'b1);
    end
    phase = "sweep_end";
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);

    phase = "latency";
    step(1'b0, 4'h3, 1'b1);
    step(1'b0, 4'h3, 1'b1);
    step(1'b0, 4'h3, 1'b0);
    step(1'b0, 4'h3, 1'b0);

    phase = "back_to_back";
    step(1'b0, 4'h5, 1'b1);
    step(1'b0, 4'h6, 1'b1);
    step(1'b0, 4'h7, 1'b1);
    step(1'b0, 4'h7, 1'b0);

    phase = "reset_mid_drive";
    step(1'b0, 4'hF, 1'b1);
    step(1'b1, 4'hF, 1'b1);
    step(1'b0, 4'hF, 1'b1);
    step(1'b0, 4'hF, 1'b0);

    phase = "keeper_hold";
    step(1'b0, 4'h9, 1'b1);
    step(1'b0, 4'h2, 1'b0);
    step(1'b0, 4'h4, 1'b0);
    step(1'b1, 4'h4, 1'b0);
    step(1'b0, 4'h4, 1'b0);

    phase = "counter_wrap";
    for (int k = 0; k < 300; k++) step(1'b0, WIDTH'($urandom), 1'b1);

    phase = "random";
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(0, 199) == 0), WIDTH'($urandom), ($urandom_range(0, 3) != 0));
    end
    step(1'b0, 4'h0, 1'b0);

    phase = "drain";
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidirectional_bus.md
Name: unidirectional_bus

Overview:
- Clocked, one-direction bus driver for a point-to-point link.
- Captures source word `a` and drive-enable `c` on each clock, then drives the registered word onto output bus `b` while enabled.
- When not enabled, `b` floats (high-Z) so other drivers or a keeper can own the net.
- Sits between a producer datapath and a shared or tristate wire segment. Data always flows a -> b, never back.

Parameters:
- WIDTH, 4, bit width of `a` and `b`.
- CNT_W, 16, width of the transfer counter `xfer_cnt`.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  source data word.
- c  input  1  drive enable; 1 = drive bus, 0 = release bus.
- b  output  WIDTH  tristate bus output.
- b_valid  output  1  registered copy of enable; high while `b` carries driven data.
- xfer_cnt  output  CNT_W  count of clock cycles in which the bus was driven.

Behaviour:
- Registers: `data_q[WIDTH-1:0]`, `en_q`, `cnt_q[CNT_W-1:0]`; all update on rising `clk` only.
- Reset (rst=1 at clk edge):
  - data_q=0, en_q=0, cnt_q=0.
  - Therefore `b` = all-Z, b_valid=0, xfer_cnt=0.
  - Reset has priority over all other inputs.
- Normal cycle (rst=0):
  - data_q <= a; en_q <= c.
  - If en_q was 1 in the cycle just ending, cnt_q <= cnt_q+1.
- Output:
  - b = en_q ? data_q : {WIDTH{1'bz}}.
  - Continuous assign from registers only; no combinational path from `a` or `c` to `b`.
  - b_valid = en_q; xfer_cnt = cnt_q.
- Latency: exactly 1 clock from (a,c) sample to `b`/b_valid update.
- Enable deassert: `b` goes Z one clock after c falls.
- Enable re-assert: the first driven value is the `a` sampled on the same edge; there is no stale data.
- Data change while enabled: the new word appears on `b` the next cycle, with no gap.
- Counter width: `xfer_cnt` wraps modulo 2^CNT_W, from all-ones to 0, with no saturation flag.
- Reset mid-transfer: `b` releases to Z on the reset edge regardless of `c`; the counter clears.
- X on `c` outside reset: en_q takes X; no requirement beyond simulation propagation.
- No other state exists; no FSM.

Optional Feature:
- Macro: UNIDIRECTIONAL_BUS_KEEPER_EN.
- Defined:
  - Add register `hold_q[WIDTH-1:0]`, reset to 0.
  - hold_q <= data_q whenever en_q=1.
  - When en_q=0, b = hold_q, so the bus holds the last driven word and never floats.
  - After reset, `b` = 0.
  - b_valid still follows en_q, so consumers can distinguish held data from fresh data.
- Not defined: `b` = Z whenever en_q=0, as described above. No hold_q register exists.

Test Plan:
- Reset: rst=1 for 2 clks with a=4'hA, c=1 -> b=4'bzzzz, b_valid=0, xfer_cnt=0. Release rst.
- Sweep: for i=0..15, hold a=i with c=0 for 10 clks, then a=i with c=1 for 10 clks.
  - c=0 phase -> b=Z.
  - c=1 phase -> b=i from 1 clk after c rises.
  - End of sweep -> xfer_cnt=160.
- Latency: a=4'h3, c=1 at edge N -> b=4'h3 at N+1, not before. Then c=0 at edge M -> b=Z at M+1.
- Back-to-back: c=1, a=5,6,7 on consecutive edges -> b=5,6,7 on the next three cycles, with b_valid continuously 1.
- Reset mid-drive: c=1, a=4'hF, assert rst for one edge -> b=Z and xfer_cnt=0 the next cycle. Then with rst=0, b=4'hF one clk later.
- Keeper (with UNIDIRECTIONAL_BUS_KEEPER_EN): drive a=4'h9, then c=0 -> b stays 4'h9 and b_valid=0. Reset -> b=4'h0.
